preif_redirect_ctrl: RTL and testbench

- Sequencer for the pre-IF PC register. Each cycle it selects the next PC from: sequential advance, branch/jump redirect, exception entry or ERET return.
- Drives the PC register's write enable and next-PC value.
- Honours the MIPS delay-slot rule: a resolved branch redirects only after its delay slot has been fetched.
- Buffers a redirect that cannot be applied while fetch is stalled.

---
 rtl/preif_redirect_ctrl_pkg.sv | 21 ++
 rtl/preif_redirect_ctrl_npc_sel.sv | 25 ++
 rtl/preif_redirect_ctrl.sv | 124 ++++++++++++
 tb/tb_preif_redirect_ctrl.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/preif_redirect_ctrl_pkg.sv
// Shared types and address defaults for the pre-IF PC sequencer.
// Imported by preif_redirect_ctrl and its npc_sel sub-module.
package preif_redirect_ctrl_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'hBFC0_0000;
  localparam logic [31:0] EXC_VEC_DEF  = 32'hBFC0_0380;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_DS = 2'd1,
    PENDING = 2'd2
  } redir_state_t;

  typedef enum logic [1:0] {
    SRC_SEQ  = 2'd0,
    SRC_BR   = 2'd1,
    SRC_ERET = 2'd2,
    SRC_EXC  = 2'd3
  } npc_src_t;

endpackage

// File: rtl/preif_redirect_ctrl_npc_sel.sv
// Next-PC source mux: sequential, branch target, ERET return or exception vector.
// The sequential path wraps at 32 bits; targets pass through unaligned.
module preif_redirect_ctrl_npc_sel
  import preif_redirect_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VEC = EXC_VEC_DEF
) (
  input  npc_src_t    src_i,
  input  logic [31:0] pc_cur_i,
  input  logic [31:0] br_tgt_i,
  input  logic [31:0] epc_i,
  output logic [31:0] npc_o
);

  always_comb begin
    npc_o = pc_cur_i + 32'd4;
    case (src_i)
      SRC_BR:   npc_o = br_tgt_i;
      SRC_ERET: npc_o = epc_i;
      SRC_EXC:  npc_o = EXC_VEC;
      default:  npc_o = pc_cur_i + 32'd4;
    endcase
  end

endmodule

// File: rtl/preif_redirect_ctrl.sv
// Pre-IF PC sequencer: flush/branch/sequential selection with MIPS delay-slot hold.
// Optional macro REDIRECT_CNT_EN adds a saturating count of applied redirects.
module preif_redirect_ctrl
  import preif_redirect_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] EXC_VEC  = EXC_VEC_DEF
`ifdef REDIRECT_CNT_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_cur,
  input  logic        fetch_ready,
  input  logic        br_valid,
  input  logic [31:0] br_target,
  input  logic        br_ds_fetched,
  input  logic        exc_valid,
  input  logic        eret_valid,
  input  logic [31:0] epc,
  output logic        pc_wr,
  output logic [31:0] npc,
  output logic        busy
`ifdef REDIRECT_CNT_EN
  , output logic [CNT_W-1:0] redirect_cnt
`endif
);

  redir_state_t state_q, state_d;
  logic [31:0]  tgt_q, tgt_d;
  npc_src_t     src;
  logic [31:0]  redir_tgt;
  logic         flush;

  assign flush = exc_valid | eret_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tgt_q   <= RESET_PC;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
    end
  end

  // A taken branch whose delay slot is accepted in the same cycle skips WAIT_DS.
  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (br_valid) begin
            tgt_d = br_target;
            if (br_ds_fetched) state_d = fetch_ready ? IDLE : PENDING;
            else               state_d = fetch_ready ? PENDING : WAIT_DS;
          end
        end
        WAIT_DS: if (fetch_ready) state_d = PENDING;
        PENDING: if (fetch_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    src       = SRC_SEQ;
    redir_tgt = tgt_q;
    pc_wr     = fetch_ready;
    if (exc_valid) begin
      src   = SRC_EXC;
      pc_wr = 1'b1;
    end else if (eret_valid) begin
      src   = SRC_ERET;
      pc_wr = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (br_valid && br_ds_fetched) begin
            src       = SRC_BR;
            redir_tgt = br_target;
          end
        end
        PENDING: src = SRC_BR;
        default: src = SRC_SEQ;
      endcase
    end
    if (rst) pc_wr = 1'b0;
  end

  assign busy = (state_q != IDLE);

  preif_redirect_ctrl_npc_sel #(
    .EXC_VEC (EXC_VEC)
  ) u_npc_sel (
    .src_i    (src),
    .pc_cur_i (pc_cur),
    .br_tgt_i (redir_tgt),
    .epc_i    (epc),
    .npc_o    (npc)
  );

`ifdef REDIRECT_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (pc_wr && (npc != pc_cur + 32'd4) && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign redirect_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_preif_redirect_ctrl.sv
// Self-checking bench for preif_redirect_ctrl: directed scenarios then random traffic
// against a redirect-queue reference model; honours REDIRECT_CNT_EN.
module tb_preif_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_cur;
  logic        fetch_ready;
  logic        br_valid;
  logic [31:0] br_target;
  logic        br_ds_fetched;
  logic        exc_valid;
  logic        eret_valid;
  logic [31:0] epc;
  logic        pc_wr;
  logic [31:0] npc;
  logic        busy;
`ifdef REDIRECT_CNT_EN
  logic [31:0] redirect_cnt;
`endif

  always #5 clk = ~clk;

  preif_redirect_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .pc_cur        (pc_cur),
    .fetch_ready   (fetch_ready),
    .br_valid      (br_valid),
    .br_target     (br_target),
    .br_ds_fetched (br_ds_fetched),
    .exc_valid     (exc_valid),
    .eret_valid    (eret_valid),
    .epc           (epc),
    .pc_wr         (pc_wr),
    .npc           (npc),
    .busy          (busy)
`ifdef REDIRECT_CNT_EN
    , .redirect_cnt (redirect_cnt)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: an outstanding branch waits for its delay slot, then for an accept.
  bit          m_held     = 1'b0;
  bit          m_need_ds  = 1'b0;
  logic [31:0] m_tgt      = 32'h0;
  logic [31:0] m_cnt      = 32'h0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input bit r, input logic [31:0] pc, input bit rdy, input bit br,
                       input logic [31:0] tgt, input bit ds, input bit exc, input bit eret,
                       input logic [31:0] e);
    @(negedge clk);
    rst = r; pc_cur = pc; fetch_ready = rdy; br_valid = br; br_target = tgt;
    br_ds_fetched = ds; exc_valid = exc; eret_valid = eret; epc = e;
    #1;
  endtask

  // Check current outputs against the model, then advance the model across the edge.
  task automatic step();
    bit          e_wr;
    logic [31:0] e_npc;
    logic [31:0] seq;
    seq   = pc_cur + 32'd4;
    e_wr  = fetch_ready;
    e_npc = seq;
    if (rst) begin
      e_wr = 1'b0;
    end else if (exc_valid) begin
      e_wr = 1'b1; e_npc = 32'hBFC0_0380;
    end else if (eret_valid) begin
      e_wr = 1'b1; e_npc = epc;
    end else if (m_held) begin
      if (!m_need_ds) e_npc = m_tgt;
    end else if (br_valid && br_ds_fetched) begin
      e_npc = br_target;
    end
    chk("pc_wr", {31'b0, pc_wr}, {31'b0, e_wr});
    if (e_wr) chk("npc", npc, e_npc);
    chk("busy", {31'b0, busy}, {31'b0, m_held});
`ifdef REDIRECT_CNT_EN
    chk("redirect_cnt", redirect_cnt, m_cnt);
`endif
    if (rst) begin
      m_held = 1'b0; m_cnt = 32'h0;
    end else begin
      if (e_wr && e_npc != seq && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      if (exc_valid || eret_valid) begin
        m_held = 1'b0;
      end else if (m_held) begin
        if (fetch_ready) begin
          if (m_need_ds) m_need_ds = 1'b0;
          else           m_held    = 1'b0;
        end
      end else if (br_valid) begin
        m_tgt = br_target;
        if (br_ds_fetched) begin
          m_held = !fetch_ready; m_need_ds = 1'b0;
        end else begin
          m_held = 1'b1; m_need_ds = !fetch_ready;
        end
      end
    end
    @(posedge clk);
  endtask

  initial begin
    rst = 1'b1; pc_cur = 32'h0; fetch_ready = 1'b0; br_valid = 1'b0; br_target = 32'h0;
    br_ds_fetched = 1'b0; exc_valid = 1'b0; eret_valid = 1'b0; epc = 32'h0;
    repeat (2) @(posedge clk);

    drive(1, 32'hBFC0_0000, 1, 0, 0, 0, 0, 0, 0);
    chk("rst_pc_wr", {31'b0, pc_wr}, 32'd0);
    step();

    drive(0, 32'hBFC0_0000, 1, 0, 0, 0, 0, 0, 0);
    chk("seq0", npc, 32'hBFC0_0004); step();
    drive(0, 32'hBFC0_0004, 1, 0, 0, 0, 0, 0, 0);
    chk("seq1", npc, 32'hBFC0_0008); step();
    drive(0, 32'hBFC0_0008, 1, 0, 0, 0, 0, 0, 0);
    chk("seq2", npc, 32'hBFC0_000C); step();

    drive(0, 32'hBFC0_000C, 1, 1, 32'h8000_0100, 1, 0, 0, 0);
    chk("br_now", npc, 32'h8000_0100); step();

    drive(0, 32'h8000_0100, 0, 1, 32'h8000_0200, 0, 0, 0, 0); step();
    drive(0, 32'h8000_0104, 0, 0, 0, 0, 0, 0, 0);
    chk("stall_busy", {31'b0, busy}, 32'd1); step();
    drive(0, 32'h8000_0104, 0, 0, 0, 0, 0, 0, 0); step();
    drive(0, 32'h8000_0104, 1, 0, 0, 0, 0, 0, 0);
    chk("ds_accept", npc, 32'h8000_0108); step();
    drive(0, 32'h8000_0108, 1, 0, 0, 0, 0, 0, 0);
    chk("br_apply", npc, 32'h8000_0200); step();
    drive(0, 32'h8000_0200, 1, 0, 0, 0, 0, 0, 0);
    chk("br_idle", {31'b0, busy}, 32'd0); step();

    drive(0, 32'h8000_0204, 0, 1, 32'h8000_0300, 1, 0, 0, 0); step();
    drive(0, 32'h8000_0204, 0, 0, 0, 0, 1, 0, 0);
    chk("exc_flush", npc, 32'hBFC0_0380); step();
    drive(0, 32'hBFC0_0380, 1, 0, 0, 0, 0, 0, 0);
    chk("exc_drop", npc, 32'hBFC0_0384); step();

    drive(0, 32'hBFC0_0384, 0, 0, 0, 0, 1, 1, 32'h8000_1000);
    chk("exc_over_eret", npc, 32'hBFC0_0380); step();
    drive(0, 32'hBFC0_0380, 0, 0, 0, 0, 0, 1, 32'h8000_1000);
    chk("eret", npc, 32'h8000_1000); step();

    drive(0, 32'hFFFF_FFFC, 1, 0, 0, 0, 0, 0, 0);
    chk("wrap", npc, 32'h0000_0000); step();

    drive(0, 32'h0000_0000, 0, 1, 32'h8000_0400, 0, 0, 0, 0); step();
    drive(1, 32'h0000_0004, 0, 0, 0, 0, 0, 0, 0); step();
    drive(0, 32'hBFC0_0000, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_drop", {31'b0, busy}, 32'd0); step();

    for (int i = 0; i < 3000; i++) begin
      logic [31:0] pc;
      pc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : $urandom;
      drive(($urandom_range(0, 63) == 0), pc, $urandom_range(0, 1) != 0,
            $urandom_range(0, 3) == 0, $urandom, $urandom_range(0, 1) != 0,
            $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0, $urandom);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
